// File: rtl/qam_demod_detector.sv
// qam_demod_detector: coherent I/Q integrate-and-dump detector slicing QAM symbols from mixer output
module qam_demod_detector #(
    parameter int SYMBOL_LEN = 10000,
    parameter int ACC_W      = 32,
    parameter int THRESH     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       sym_start,
    input  logic [7:0] signal_in,
    input  logic [7:0] sin_in,
    input  logic [7:0] cos_in,
    output logic [1:0] data_out,
    output logic       data_valid,
    output logic       low_energy,
    output logic       sync_err,
    output logic       locked
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [15:0]  LAST_CNT = 16'(SYMBOL_LEN);
    localparam logic [ACC_W:0] THR    = (ACC_W + 1)'(THRESH);

    state_t                  state;
    logic [15:0]             count;
    logic                    take, abort, first, last;
    logic signed [15:0]      sig_s, sin_s, cos_s, p_i, p_q;
    logic                    v1, f1, l1;
    logic signed [ACC_W-1:0] acc_i, acc_q, ext_i, ext_q, fin_i, fin_q;
    logic [ACC_W:0]          abs_i, abs_q;

    // Sample qualification, symbol framing tags and the decision datapath
    always_comb begin
        take  = sample_en && (state == ACCUM || sym_start);
        abort = state == ACCUM && sym_start && count != 16'd0;
        first = sym_start || count == 16'd0;
        last  = !abort && count + 16'd1 == LAST_CNT;
        sig_s = 16'($signed(signal_in));
        sin_s = 16'($signed(sin_in));
        cos_s = 16'($signed(cos_in));
        ext_i = {{(ACC_W - 16){p_i[15]}}, p_i};
        ext_q = {{(ACC_W - 16){p_q[15]}}, p_q};
        fin_i = (f1 ? '0 : acc_i) + ext_i;
        fin_q = (f1 ? '0 : acc_q) + ext_q;
        abs_i = fin_i[ACC_W-1] ? -{fin_i[ACC_W-1], fin_i} : {fin_i[ACC_W-1], fin_i};
        abs_q = fin_q[ACC_W-1] ? -{fin_q[ACC_W-1], fin_q} : {fin_q[ACC_W-1], fin_q};
    end

    // Framing FSM: lock on first sym_start, free-run symbol counter, flag misaligned sym_start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= take && abort;
            if (take) begin
                state  <= ACCUM;
                locked <= 1'b1;
                count  <= last ? 16'd0 : abort ? 16'd1 : count + 16'd1;
            end
        end
    end

    // Stage 1: correlate the sample against both references and carry the framing tags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            f1  <= 1'b0;
            l1  <= 1'b0;
            p_i <= '0;
            p_q <= '0;
        end else begin
            v1 <= take;
            if (take) begin
                p_i <= sig_s * cos_s;
                p_q <= sig_s * sin_s;
                f1  <= first;
                l1  <= last;
            end
        end
    end

    // Stage 2: integrate (reload on first product) and slice the symbol on the last product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i      <= '0;
            acc_q      <= '0;
            data_out   <= 2'b00;
            data_valid <= 1'b0;
            low_energy <= 1'b0;
        end else begin
            data_valid <= v1 && l1;
            if (v1) begin
                acc_i <= fin_i;
                acc_q <= fin_q;
                if (l1) begin
                    data_out   <= {~fin_q[ACC_W-1], ~fin_i[ACC_W-1]};
                    low_energy <= abs_i < THR && abs_q < THR;
                end
            end
        end
    end
endmodule
